// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: constant clog2 and parameter legality check.
// Elaboration-time only; no logic, no latency, no flow control.
package fifo_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    function automatic bit params_ok(input int data_w, input int depth,
                                     input int af_level, input int ae_level);
        return (data_w >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0)
            && (af_level >= 1) && (af_level <= depth - 1)
            && (ae_level >= 1) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port (1-cycle latency).
// No backpressure; read is read-first when both ports hit the same address.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Array kept reset-free so it maps onto RAM primitives.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_param.sv
// Synchronous circular FIFO with registered read data (1-cycle read latency) and status flags.
// Writes dropped when full unless a read frees a slot that cycle; reads dropped when empty; both sticky-flagged.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    wr_en,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       data_out,
    output logic                    rd_valid,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    if (!params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $fatal(1, "fifo_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_rd_valid;
    logic          r_overflow;
    logic          r_underflow;
    logic          w_empty;
    logic          w_full;
    logic          w_rd_acc;
    logic          w_wr_acc;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    // A read on a full FIFO frees the slot the simultaneous write reuses.
    assign w_rd_acc = rd_en & ~w_empty;
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_rd_valid <= w_rd_acc;
            if (wr_en & ~w_wr_acc) r_overflow  <= 1'b1;
            if (rd_en & w_empty)   r_underflow <= 1'b1;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (data_out)
    );

    assign rd_valid     = r_rd_valid;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_count <= CW'(AE_LEVEL));
    assign almost_full  = (r_count >= CW'(AF_LEVEL));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
